// File: rtl/seg7_scan6.sv
// seg7_scan6 -- time-multiplexed driver for a six-digit HH:MM:SS 7-segment display.
//
// Scans one digit per SCAN_DIV clocks in the order 0..5, where digit 0 is seconds
// units and digit 5 is hours tens. The BCD value and the three display masks are
// snapshotted once per frame, so a counter carry mid-frame never tears the display.
// Blinking digits toggle every BLINK_FRAMES frames. Decimal points never blink.
//
// Ports:
//   rst          async active-low reset
//   clk          system clock
//   en           display enable; 0 blanks the outputs and freezes the scan
//   bcd_in       {H1,H0,M1,M0,S1,S0}; digit i in [4i+3:4i]
//   blink_mask   bit i blinks digit i
//   dp_mask      bit i lights the decimal point of digit i
//   lz_blank     blank hours tens when it is 0
//   seg          {g,f,e,d,c,b,a} of the active digit
//   dp           decimal point of the active digit
//   an           one-hot digit enables, an[i] selects digit i
//   frame_start  one-cycle pulse while an first shows digit 0 of a new frame
module seg7_scan6 #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        en,
  input  logic [23:0] bcd_in,
  input  logic [5:0]  blink_mask,
  input  logic [5:0]  dp_mask,
  input  logic        lz_blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an,
  output logic        frame_start
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  // Everything that is frozen for the duration of one frame.
  typedef struct packed {
    logic [23:0] bcd;
    logic [5:0]  blink;
    logic [5:0]  dp;
    logic        lz;
  } snap_t;

  // Active-high gfedcba font; 10..15 show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  snap_t            snap_q, snap_d;
  logic             load_pending_q, load_pending_d;

  logic [5:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_start_q, frame_start_d;

  logic             tick;
  logic             wrap;
  logic             load;
  logic [3:0]       digit;
  logic             blink_bit;
  logic             dp_bit;
  logic [5:0]       an_sel;
  logic             blank;

  // Next-state logic. The output registers are fed from the next-state idx,
  // snapshot and blink phase, so the displayed digit changes exactly one clock
  // after the tick and frame_start lines up with the first digit-0 cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    div_d          = div_q;
    idx_d          = idx_q;
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;
    snap_d         = snap_q;
    load_pending_d = load_pending_q;

    tick = en && (div_q == DIV_LAST);
    wrap = tick && (idx_q == 3'd5);
    // A pending load fires on the first enabled cycle after reset.
    load = wrap || (en && load_pending_q);

    if (en) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
    if (tick) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    if (wrap) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    if (load) begin
      snap_d         = '{bcd: bcd_in, blink: blink_mask, dp: dp_mask, lz: lz_blank};
      load_pending_d = 1'b0;
    end

    digit     = snap_d.bcd[3:0];
    blink_bit = snap_d.blink[0];
    dp_bit    = snap_d.dp[0];
    an_sel    = 6'b000001;
    for (int i = 1; i < 6; i++) begin
      if (idx_d == 3'(i)) begin
        digit     = snap_d.bcd[4*i +: 4];
        blink_bit = snap_d.blink[i];
        dp_bit    = snap_d.dp[i];
        an_sel    = 6'b000001 << i;
      end
    end

    blank = (blink_bit && blink_phase_d) ||
            ((idx_d == 3'd5) && snap_d.lz && (digit == 4'd0));

    // The dp ignores blanking so the colon stays steady while a digit blinks.
    an_d          = en ? an_sel : 6'b000000;
    seg_d         = (en && !blank) ? decode(digit) : 7'h00;
    dp_d          = en && dp_bit;
    frame_start_d = load;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q          <= '0;
      idx_q          <= 3'd0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      // NOTE: the snapshot is reset as well; it sits behind a pending load, so
      // the value is never shown, but it keeps the outputs fully defined.
      snap_q         <= '0;
      load_pending_q <= 1'b1;
      an_q           <= 6'b000000;
      seg_q          <= 7'h00;
      dp_q           <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      div_q          <= div_d;
      idx_q          <= idx_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      snap_q         <= snap_d;
      load_pending_q <= load_pending_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      frame_start_q  <= frame_start_d;
    end
  end

  // Pin polarity is applied last; all logic above is active-high.
  assign an          = AN_ACTIVE_LOW  ? ~an_q  : an_q;
  assign seg         = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp          = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;
  assign frame_start = frame_start_q;

endmodule
